// File: rtl/tank_input_pkg.sv
// Shared constants and types for the PS/2 keyboard front end of the tank controls.
package tank_input_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam int KEY_NUM_DEFAULT = 10;
    localparam logic [79:0] KEY_CODES_DEFAULT = 80'h5A_4B_3B_42_43_29_23_1C_1B_1D;

    // Player 1 on WSAD + space, player 2 on IKJL + enter.
    localparam int KEY_UP1    = 0;
    localparam int KEY_DOWN1  = 1;
    localparam int KEY_LEFT1  = 2;
    localparam int KEY_RIGHT1 = 3;
    localparam int KEY_FIRE1  = 4;
    localparam int KEY_UP2    = 5;
    localparam int KEY_DOWN2  = 6;
    localparam int KEY_LEFT2  = 7;
    localparam int KEY_RIGHT2 = 8;
    localparam int KEY_FIRE2  = 9;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } scan_evt_t;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 byte receiver: pin synchronisers, kclk glitch filter, 11-bit framing FSM
// and inter-edge timeout. byte_valid/err are single-cycle strobes on the deciding edge.
module ps2_rx_frame
    import tank_input_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic       kclk,
    input  logic       kdata,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    kclk_sync, kdata_sync;
    logic          kclk_f;
    logic [FW-1:0] filt_cnt;
    logic          filt_hit, fall, kd, tout;

    rx_state_t     state, state_n;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic          parity_bit;
    logic [TW-1:0] tout_cnt;

    assign kd       = kdata_sync[1];
    assign filt_hit = (kclk_sync[1] != kclk_f) && (filt_cnt == FW'(FILTER_LEN - 1));
    assign fall     = filt_hit && kclk_f;
    assign tout     = (state != RX_IDLE) && !fall && (tout_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign rx_byte  = shift;

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            kclk_sync  <= 2'b11;
            kdata_sync <= 2'b11;
        end else begin
            kclk_sync  <= {kclk_sync[0], kclk};
            kdata_sync <= {kdata_sync[0], kdata};
        end
    end

    // Any cycle where the synchronised level agrees with the filtered one restarts the run.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            kclk_f   <= 1'b1;
            filt_cnt <= '0;
        end else if (kclk_sync[1] != kclk_f) begin
            if (filt_hit) begin
                kclk_f   <= kclk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end else begin
            filt_cnt <= '0;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state      <= RX_IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            parity_bit <= 1'b0;
            tout_cnt   <= '0;
        end else begin
            state <= state_n;
            if (state == RX_IDLE || fall)
                tout_cnt <= '0;
            else
                tout_cnt <= tout_cnt + 1'b1;
            if (fall) begin
                case (state)
                    RX_IDLE:   bit_cnt <= '0;
                    RX_DATA: begin
                        shift   <= {kd, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    RX_PARITY: parity_bit <= kd;
                    default:   ;
                endcase
            end
        end
    end

    always_comb begin
        state_n    = state;
        byte_valid = 1'b0;
        err        = 1'b0;
        case (state)
            RX_IDLE:
                if (fall) begin
                    if (!kd) state_n = RX_DATA;
                    else     err     = 1'b1;
                end
            RX_DATA:
                if (fall && bit_cnt == 3'd7) state_n = RX_PARITY;
            RX_PARITY:
                if (fall) state_n = RX_STOP;
            RX_STOP:
                if (fall) begin
                    state_n = RX_IDLE;
                    if (kd && (^{shift, parity_bit})) byte_valid = 1'b1;
                    else                              err        = 1'b1;
                end
            default: state_n = RX_IDLE;
        endcase
        if (tout) begin
            state_n = RX_IDLE;
            err     = 1'b1;
        end
    end

endmodule

// File: rtl/ps2_key_matrix.sv
// PS/2 keyboard front end: E0/F0 prefix decode over ps2_rx_frame bytes and an
// independent held/released bit per mapped key.
module ps2_key_matrix
    import tank_input_pkg::*;
#(
    parameter int                      NUM_KEYS       = KEY_NUM_DEFAULT,
    parameter logic [NUM_KEYS*8-1:0]   KEY_CODES      = KEY_CODES_DEFAULT,
    parameter logic [NUM_KEYS-1:0]     KEY_EXT        = '0,
    parameter int                      FILTER_LEN     = 8,
    parameter int                      TIMEOUT_CYCLES = 50000
) (
    input  logic                clk_50m,
    input  logic                rst,
    input  logic                kclk,
    input  logic                kdata,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic                scan_valid,
    output logic [7:0]          scan_code,
    output logic                scan_break,
    output logic                scan_ext,
    output logic                frame_err
);

    logic       byte_valid, rx_err;
    logic [7:0] rx_byte;
    logic       is_ext, is_brk, code_strobe;
    logic       ext_pending, brk_pending;
    scan_evt_t  scan_q;

    ps2_rx_frame #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk_50m    (clk_50m),
        .rst        (rst),
        .kclk       (kclk),
        .kdata      (kdata),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .err        (rx_err)
    );

    assign is_ext      = (rx_byte == PS2_PREFIX_EXT);
    assign is_brk      = (rx_byte == PS2_PREFIX_BRK);
    assign code_strobe = byte_valid && !is_ext && !is_brk;

    assign scan_code  = scan_q.code;
    assign scan_break = scan_q.brk;
    assign scan_ext   = scan_q.ext;

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            ext_pending <= 1'b0;
            brk_pending <= 1'b0;
            scan_valid  <= 1'b0;
            scan_q      <= '0;
            frame_err   <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= rx_err;
            if (rx_err) begin
                ext_pending <= 1'b0;
                brk_pending <= 1'b0;
            end else if (byte_valid) begin
                if (is_ext) begin
                    ext_pending <= 1'b1;
                end else if (is_brk) begin
                    brk_pending <= 1'b1;
                end else begin
                    scan_valid  <= 1'b1;
                    scan_q      <= '{code: rx_byte, brk: brk_pending, ext: ext_pending};
                    ext_pending <= 1'b0;
                    brk_pending <= 1'b0;
                end
            end
        end
    end

    // Every key compares against the byte on its own, so duplicate codes update together.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        logic hit;
        assign hit = code_strobe && (rx_byte == KEY_CODES[8*i +: 8]) &&
                     (KEY_EXT[i] == ext_pending);

        always_ff @(posedge clk_50m) begin
            if (rst) begin
                key_state[i] <= 1'b0;
                key_press[i] <= 1'b0;
            end else begin
                key_press[i] <= hit && !brk_pending && !key_state[i];
                if (hit) key_state[i] <= !brk_pending;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Randomised PS/2 stimulus against a byte-level event model of the key tracker.
module tb_ps2_key_matrix;

    localparam int          NK   = 10;
    localparam int          FL   = 8;
    localparam int          TO   = 2000;
    localparam logic [79:0] CODES = 80'h5A_4B_3B_42_43_29_23_1C_1B_1D;
    localparam logic [9:0]  KEXT = 10'h040;

    logic          clk_50m = 1'b0;
    logic          rst = 1'b1, kclk = 1'b1, kdata = 1'b1;
    logic [NK-1:0] key_state, key_press;
    logic          scan_valid, scan_break, scan_ext, frame_err;
    logic [7:0]    scan_code;

    always #10 clk_50m = ~clk_50m;

    ps2_key_matrix #(
        .NUM_KEYS(NK), .KEY_CODES(CODES), .KEY_EXT(KEXT),
        .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_50m(clk_50m), .rst(rst), .kclk(kclk), .kdata(kdata),
        .key_state(key_state), .key_press(key_press),
        .scan_valid(scan_valid), .scan_code(scan_code),
        .scan_break(scan_break), .scan_ext(scan_ext), .frame_err(frame_err)
    );

    typedef struct {
        bit            is_err;
        logic [7:0]    code;
        bit            brk;
        bit            ext;
        logic [NK-1:0] keys;
        logic [NK-1:0] press;
    } exp_t;

    exp_t          q[$];
    logic [NK-1:0] m_keys = '0;
    bit            m_ext = 0, m_brk = 0;
    logic [NK-1:0] cur_keys = '0;
    int            checks = 0, failures = 0;
    int            scan_cnt = 0, press0_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // What a good byte must do, straight from the decode rules.
    function automatic void model_byte(input logic [7:0] b);
        exp_t e;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            e.is_err = 0; e.code = b; e.brk = m_brk; e.ext = m_ext; e.press = '0;
            for (int i = 0; i < NK; i++)
                if (CODES[8*i +: 8] == b && KEXT[i] == m_ext) begin
                    if (!m_brk && !m_keys[i]) e.press[i] = 1'b1;
                    m_keys[i] = !m_brk;
                end
            e.keys = m_keys;
            q.push_back(e);
            m_ext = 0; m_brk = 0;
        end
    endfunction

    function automatic void model_err();
        exp_t e;
        e.is_err = 1; e.code = '0; e.brk = 0; e.ext = 0; e.keys = m_keys; e.press = '0;
        q.push_back(e);
        m_ext = 0; m_brk = 0;
    endfunction

    task automatic ps2_bit(input logic d, input int h);
        kdata = d;
        repeat (h) @(negedge clk_50m);
        kclk = 1'b0;
        repeat (h) @(negedge clk_50m);
        kclk = 1'b1;
    endtask

    task automatic send_raw(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int h;
        h = $urandom_range(12, 24);
        ps2_bit(1'b0, h);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], h);
        ps2_bit((~^b) ^ bad_par, h);
        ps2_bit(!bad_stop, h);
        kdata = 1'b1;
        repeat (40) @(negedge clk_50m);
    endtask

    task automatic send(input logic [7:0] b);
        model_byte(b);
        send_raw(b, 0, 0);
    endtask

    task automatic send_bad(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        model_err();
        send_raw(b, bad_par, bad_stop);
    endtask

    task automatic start_err();
        model_err();
        ps2_bit(1'b1, 16);
        repeat (40) @(negedge clk_50m);
    endtask

    task automatic glitch(input int len);
        kclk = 1'b0;
        repeat (len) @(negedge clk_50m);
        kclk = 1'b1;
        repeat (30) @(negedge clk_50m);
    endtask

    task automatic compare_cycle();
        exp_t e;
        if (rst) begin
            cur_keys = '0;
        end else if (scan_valid || frame_err) begin
            if (scan_valid) scan_cnt++;
            if (key_press[0]) press0_cnt++;
            if (q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_event: scan_valid=%b frame_err=%b code=%h, required no event at %0t",
                         scan_valid, frame_err, scan_code, $time);
            end else begin
                e = q.pop_front();
                if (e.is_err) begin
                    chk("err_strobes", 32'({scan_valid, frame_err}), 32'b01);
                    chk("err_keys", 32'(key_state), 32'(cur_keys));
                    chk("err_press", 32'(key_press), 32'd0);
                end else begin
                    chk("scan_strobes", 32'({scan_valid, frame_err}), 32'b10);
                    chk("scan_code", 32'(scan_code), 32'(e.code));
                    chk("scan_flags", 32'({scan_break, scan_ext}), 32'({e.brk, e.ext}));
                    chk("scan_keys", 32'(key_state), 32'(e.keys));
                    chk("scan_press", 32'(key_press), 32'(e.press));
                    cur_keys = e.keys;
                end
            end
        end else begin
            chk("idle_keys", 32'(key_state), 32'(cur_keys));
            chk("idle_press", 32'(key_press), 32'd0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_key_state"}, 32'(key_state), 32'd0);
        chk({tag, "_key_press"}, 32'(key_press), 32'd0);
        chk({tag, "_strobes"}, 32'({scan_valid, frame_err}), 32'd0);
        chk({tag, "_scan"}, 32'({scan_code, scan_break, scan_ext}), 32'd0);
    endtask

    task automatic stimulus();
        int s0, p0, r;
        logic [7:0] b;
        rst = 1'b1;
        repeat (5) @(negedge clk_50m);
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (20) @(negedge clk_50m);

        // make then break of one key
        s0 = scan_cnt;
        send(8'h1D);
        chk("model_make_1d", 32'(m_keys), 32'h001);
        chk("dut_make_1d", 32'(key_state), 32'h001);
        send(8'hF0); send(8'h1D);
        chk("dut_break_1d", 32'(key_state), 32'h000);
        chk("scan_count_mb", 32'(scan_cnt - s0), 32'd2);

        // two keys held independently
        send(8'h1D); send(8'h43);
        chk("model_two_keys", 32'(m_keys), 32'h021);
        chk("dut_two_keys", 32'(key_state), 32'h021);
        send(8'hF0); send(8'h1D);
        chk("dut_one_released", 32'(key_state), 32'h020);
        send(8'hF0); send(8'h43);

        // typematic repeat
        s0 = scan_cnt; p0 = press0_cnt;
        repeat (5) send(8'h1D);
        chk("typematic_scans", 32'(scan_cnt - s0), 32'd5);
        chk("typematic_press", 32'(press0_cnt - p0), 32'd1);
        chk("typematic_keys", 32'(key_state), 32'h001);
        send(8'hF0); send(8'h1D);

        // parity error, then a good frame
        send_bad(8'h1D, 1, 0);
        chk("parity_err_keys", 32'(key_state), 32'h000);
        send(8'h29);
        chk("after_err_29", 32'(key_state), 32'h010);
        send(8'hF0); send(8'h29);

        // break prefix lost to a timeout
        send(8'hF0);
        model_err();
        ps2_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) ps2_bit(i[0], 16);
        kdata = 1'b1;
        repeat (TO + 300) @(negedge clk_50m);
        send(8'h1B);
        chk("timeout_then_make", 32'(key_state), 32'h002);
        send(8'hF0); send(8'h1B);

        // extended-only key
        send(8'hE0); send(8'h42);
        chk("ext_key6", 32'(key_state), 32'h040);
        send(8'hE0); send(8'hF0); send(8'h42);
        send(8'h42);
        chk("plain_42_ignored", 32'(key_state), 32'h000);

        // sub-filter glitches must not look like edges; a lone high start bit must
        for (int i = 0; i < 4; i++) glitch($urandom_range(1, FL - 1));
        start_err();

        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 99);
            b = 8'($urandom_range(0, 255));
            if (r < 8)       send_bad(b, 1, 0);
            else if (r < 12) send_bad(b, 0, 1);
            else if (r < 15) start_err();
            else if (r < 18) glitch($urandom_range(1, FL - 1));
            else begin
                r = $urandom_range(0, 9);
                if (r < 5)      b = CODES[8*$urandom_range(0, NK-1) +: 8];
                else if (r < 6) b = 8'hE0;
                else if (r < 8) b = 8'hF0;
                send(b);
            end
        end

        // reset mid-frame with a key held and a break prefix pending
        send(8'h1D); send(8'hF0);
        chk("queue_drained_pre_rst", 32'(q.size()), 32'd0);
        ps2_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1, 16);
        rst = 1'b1;
        m_keys = '0; m_ext = 0; m_brk = 0;
        repeat (4) @(negedge clk_50m);
        rst = 1'b0;
        @(negedge clk_50m);
        chk_all_zero("post_rst");
        repeat (20) @(negedge clk_50m);
        send(8'h1D);
        chk("post_rst_make", 32'(key_state), 32'h001);

        repeat (100) @(negedge clk_50m);
        chk("queue_drained_end", 32'(q.size()), 32'd0);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk_50m);
                compare_cycle();
            end
            stimulus();
        join_any
        disable fork;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
